// File: rtl/l2arb_pkg.sv
// Shared state encoding, channel-count limits and index-width helper for the L2 request arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package l2arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int unsigned N_CH_MIN = 2;
  localparam int unsigned N_CH_MAX = 8;

  // Bits needed to hold a channel index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Winner select: first requester at or after ptr, wrapping to index 0; ptr = 0 gives fixed priority.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_arbiter
  import l2arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx
);

  int unsigned ptr_u;
  logic        found;

  assign ptr_u = 32'(ptr);

  // Upper pass covers ptr..N-1, lower pass covers the wrapped 0..ptr-1 range.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= ptr_u)) begin
        found     = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Funnels N_CH L1 request channels onto one L2 port, one transaction in flight (L2ARB_RR_EN: round-robin, else fixed priority).
// Latency: l2_req one cycle after ch_req is seen; ch_addrOK/ch_dataOK/ch_rdata same cycle as l2_addrOK/l2_dataOK.
// Backpressure: losing channels hold ch_req until their ch_addrOK; one idle bubble between back-to-back transactions.
module l2_req_arbiter
  import l2arb_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH-1:0]        ch_wr,
  input  logic [N_CH*ADDR_W-1:0] ch_addr,
  input  logic [N_CH*32-1:0]     ch_wdata,
  input  logic [N_CH*4-1:0]      ch_wstrb,
  input  logic [N_CH*2-1:0]      ch_size,
  input  logic [N_CH-1:0]        ch_SUC,
  output logic [N_CH-1:0]        ch_addrOK,
  output logic [N_CH-1:0]        ch_dataOK,
  output logic [LINE_W-1:0]      ch_rdata,
  output logic                   l2_req,
  output logic                   l2_wr,
  output logic                   l2_SUC,
  output logic [ADDR_W-1:0]      l2_addr,
  output logic [31:0]            l2_wdata,
  output logic [3:0]             l2_wstrb,
  output logic [1:0]             l2_size,
  input  logic                   l2_addrOK,
  input  logic                   l2_dataOK,
  input  logic [LINE_W-1:0]      l2_rdata
);

  localparam int unsigned GW = idx_w(N_CH);

  if ((N_CH < N_CH_MIN) || (N_CH > N_CH_MAX)) begin : g_bad_n_ch
    $error("l2_req_arbiter: N_CH outside supported range");
  end

  arb_state_e      state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   rr_ptr;
  logic [N_CH-1:0] win_oh;
  logic [GW-1:0]   win_idx;
  logic [N_CH-1:0] grant_oh;
  logic            req_any;
  logic            in_addr;
  logic            in_data;

  // Per-channel views of the flattened request fields.
  logic [ADDR_W-1:0] addr_a  [N_CH];
  logic [31:0]       wdata_a [N_CH];
  logic [3:0]        wstrb_a [N_CH];
  logic [1:0]        size_a  [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign addr_a[i]  = ch_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = ch_wdata[i*32 +: 32];
    assign wstrb_a[i] = ch_wstrb[i*4 +: 4];
    assign size_a[i]  = ch_size[i*2 +: 2];
  end

  rr_arbiter #(
    .N  (N_CH),
    .IW (GW)
  ) u_rr (
    .req     (ch_req),
    .ptr     (rr_ptr),
    .gnt_oh  (win_oh),
    .gnt_idx (win_idx)
  );

  assign req_any = |win_oh;

  // Transaction sequencer: latch the winner in IDLE, wait for address accept, then for data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant <= win_idx;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (l2_addrOK) state <= DATA;
        end
        DATA: begin
          if (l2_dataOK) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L2ARB_RR_EN
  // Move the search start to the channel after the one just granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if ((state == IDLE) && req_any) begin
      rr_ptr <= (win_idx == GW'(N_CH - 1)) ? '0 : (win_idx + GW'(1));
    end
  end
`else
  assign rr_ptr = '0;
`endif

  assign in_addr  = (state == ADDR);
  assign in_data  = (state == DATA);
  assign grant_oh = N_CH'(1) << grant;

  // Downstream request fields are live only while the address phase is open.
  assign l2_req   = in_addr;
  assign l2_wr    = in_addr & ch_wr[grant];
  assign l2_SUC   = in_addr & ch_SUC[grant];
  assign l2_addr  = in_addr ? addr_a[grant]  : '0;
  assign l2_wdata = in_addr ? wdata_a[grant] : '0;
  assign l2_wstrb = in_addr ? wstrb_a[grant] : '0;
  assign l2_size  = in_addr ? size_a[grant]  : '0;

  // Handshakes outside their own phase are dropped here.
  assign ch_addrOK = (in_addr && l2_addrOK) ? grant_oh : '0;
  assign ch_dataOK = (in_data && l2_dataOK) ? grant_oh : '0;
  assign ch_rdata  = (in_data && l2_dataOK) ? l2_rdata : '0;

endmodule

// File: tb/tb_l2_req_arbiter.sv
module tb_l2_req_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Two-channel instance
  logic [1:0]   ch_req, ch_wr, ch_SUC, ch_addrOK, ch_dataOK;
  logic [63:0]  ch_addr, ch_wdata;
  logic [7:0]   ch_wstrb;
  logic [3:0]   ch_size;
  logic [127:0] ch_rdata, l2_rdata;
  logic         l2_req, l2_wr, l2_SUC, l2_addrOK, l2_dataOK;
  logic [31:0]  l2_addr, l2_wdata;
  logic [3:0]   l2_wstrb;
  logic [1:0]   l2_size;

  // Four-channel instance
  logic [3:0]   q_ch_req, q_ch_wr, q_ch_SUC, q_ch_addrOK, q_ch_dataOK;
  logic [127:0] q_ch_addr, q_ch_wdata, q_ch_rdata, q_l2_rdata;
  logic [15:0]  q_ch_wstrb;
  logic [7:0]   q_ch_size;
  logic         q_l2_req, q_l2_wr, q_l2_SUC, q_l2_addrOK, q_l2_dataOK;
  logic [31:0]  q_l2_addr, q_l2_wdata;
  logic [3:0]   q_l2_wstrb;
  logic [1:0]   q_l2_size;

  int n_chk = 0;
  int n_err = 0;

  l2_req_arbiter #(.N_CH(2), .ADDR_W(32), .LINE_W(128)) dut (
    .clk(clk), .rstn(rstn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_wstrb(ch_wstrb), .ch_size(ch_size), .ch_SUC(ch_SUC),
    .ch_addrOK(ch_addrOK), .ch_dataOK(ch_dataOK), .ch_rdata(ch_rdata),
    .l2_req(l2_req), .l2_wr(l2_wr), .l2_SUC(l2_SUC), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_wstrb(l2_wstrb), .l2_size(l2_size),
    .l2_addrOK(l2_addrOK), .l2_dataOK(l2_dataOK), .l2_rdata(l2_rdata)
  );

  l2_req_arbiter #(.N_CH(4), .ADDR_W(32), .LINE_W(128)) dut4 (
    .clk(clk), .rstn(rstn),
    .ch_req(q_ch_req), .ch_wr(q_ch_wr), .ch_addr(q_ch_addr), .ch_wdata(q_ch_wdata),
    .ch_wstrb(q_ch_wstrb), .ch_size(q_ch_size), .ch_SUC(q_ch_SUC),
    .ch_addrOK(q_ch_addrOK), .ch_dataOK(q_ch_dataOK), .ch_rdata(q_ch_rdata),
    .l2_req(q_l2_req), .l2_wr(q_l2_wr), .l2_SUC(q_l2_SUC), .l2_addr(q_l2_addr),
    .l2_wdata(q_l2_wdata), .l2_wstrb(q_l2_wstrb), .l2_size(q_l2_size),
    .l2_addrOK(q_l2_addrOK), .l2_dataOK(q_l2_dataOK), .l2_rdata(q_l2_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp2;
    logic [3:0]  exp4;
    logic [31:0] exp_a;

    ch_req = '0; ch_wr = '0; ch_SUC = '0; ch_addr = '0; ch_wdata = '0;
    ch_wstrb = '0; ch_size = '0; l2_addrOK = 1'b0; l2_dataOK = 1'b0; l2_rdata = '0;
    q_ch_req = '0; q_ch_wr = '0; q_ch_SUC = '0; q_ch_addr = '0; q_ch_wdata = '0;
    q_ch_wstrb = '0; q_ch_size = '0; q_l2_addrOK = 1'b0; q_l2_dataOK = 1'b0; q_l2_rdata = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_l2_req", l2_req, 1'b0);
    chk("rst_ch_addrOK", ch_addrOK, 2'b00);
    chk("rst_ch_dataOK", ch_dataOK, 2'b00);
    chk("rst_l2_addr", l2_addr, 32'h0);
    @(negedge clk); rstn = 1'b1;

    // Single read on ch0: cycle t is the first cycle ch_req is seen
    @(negedge clk); ch_req = 2'b01; ch_addr[31:0] = 32'h1000_0040; #1;
    chk("rd_t0_l2_req", l2_req, 1'b0);
    @(negedge clk); #1;
    chk("rd_t1_l2_req", l2_req, 1'b1);
    chk("rd_t1_l2_addr", l2_addr, 32'h1000_0040);
    chk("rd_t1_l2_wr", l2_wr, 1'b0);
    @(negedge clk); #1;
    chk("rd_t2_ch_addrOK", ch_addrOK, 2'b00);
    @(negedge clk); l2_addrOK = 1'b1; #1;
    chk("rd_t3_ch_addrOK", ch_addrOK, 2'b01);
    @(negedge clk); l2_addrOK = 1'b0; ch_req = 2'b00; #1;
    chk("rd_t4_l2_req", l2_req, 1'b0);
    chk("rd_t4_l2_addr", l2_addr, 32'h0);
    @(negedge clk); #1;
    @(negedge clk); l2_dataOK = 1'b1; l2_rdata = {4{32'hA5A5_A5A5}}; #1;
    chk("rd_t6_ch_dataOK", ch_dataOK, 2'b01);
    chk("rd_t6_ch_rdata", ch_rdata, {4{32'hA5A5_A5A5}});
    @(negedge clk); l2_dataOK = 1'b0; #1;
    chk("rd_t7_ch_dataOK", ch_dataOK, 2'b00);

    // Spurious handshakes around a ch1 read
    @(negedge clk); l2_dataOK = 1'b1; #1;
    chk("sp_idle_dok_ch_dataOK", ch_dataOK, 2'b00);
    @(negedge clk); l2_dataOK = 1'b0; ch_req = 2'b10; ch_addr[63:32] = 32'h3000_0100; #1;
    chk("sp_idle_l2_req", l2_req, 1'b0);
    @(negedge clk); l2_dataOK = 1'b1; #1;
    chk("sp_addr_l2_addr", l2_addr, 32'h3000_0100);
    chk("sp_addr_dok_ch_dataOK", ch_dataOK, 2'b00);
    @(negedge clk); l2_dataOK = 1'b0; l2_addrOK = 1'b1; #1;
    chk("sp_addr_held_l2_req", l2_req, 1'b1);
    chk("sp_ch_addrOK", ch_addrOK, 2'b10);
    @(negedge clk); l2_addrOK = 1'b0; ch_req = 2'b00; #1;
    @(negedge clk); l2_addrOK = 1'b1; #1;
    chk("sp_data_aok_ch_addrOK", ch_addrOK, 2'b00);
    chk("sp_data_l2_req", l2_req, 1'b0);
    @(negedge clk); l2_addrOK = 1'b0; l2_dataOK = 1'b1; l2_rdata = 128'h1234; #1;
    chk("sp_data_ch_dataOK", ch_dataOK, 2'b10);
    chk("sp_data_ch_rdata", ch_rdata, 128'h1234);

    // Contention: both channels hold ch_req for four transactions
    ch_addr = {32'h2222_0000, 32'h1111_0000};
    for (int k = 0; k < 4; k++) begin
`ifdef L2ARB_RR_EN
      exp2 = k[0] ? 2'b10 : 2'b01;
`else
      exp2 = 2'b01;
`endif
      exp_a = (exp2 == 2'b01) ? 32'h1111_0000 : 32'h2222_0000;
      @(negedge clk); l2_dataOK = 1'b0; ch_req = 2'b11; #1;
      chk("ct_bubble_l2_req", l2_req, 1'b0);
      @(negedge clk); l2_addrOK = 1'b1; #1;
      chk("ct_ch_addrOK", ch_addrOK, exp2);
      chk("ct_l2_addr", l2_addr, exp_a);
      @(negedge clk); l2_addrOK = 1'b0; l2_dataOK = 1'b1; #1;
      chk("ct_ch_dataOK", ch_dataOK, exp2);
    end

    // Write on ch1
    @(negedge clk); l2_dataOK = 1'b0; ch_req = 2'b10; ch_wr = 2'b10; ch_SUC = 2'b10;
    ch_wdata[63:32] = 32'hDEAD_BEEF; ch_wstrb[7:4] = 4'b0011; ch_size[3:2] = 2'd2;
    ch_addr[63:32] = 32'h4000_0008; #1;
    chk("wr_idle_l2_wr", l2_wr, 1'b0);
    chk("wr_idle_l2_wdata", l2_wdata, 32'h0);
    @(negedge clk); l2_addrOK = 1'b1; #1;
    chk("wr_l2_wr", l2_wr, 1'b1);
    chk("wr_l2_wdata", l2_wdata, 32'hDEAD_BEEF);
    chk("wr_l2_wstrb", l2_wstrb, 4'b0011);
    chk("wr_l2_SUC", l2_SUC, 1'b1);
    chk("wr_l2_size", l2_size, 2'd2);
    chk("wr_l2_addr", l2_addr, 32'h4000_0008);
    chk("wr_ch_addrOK", ch_addrOK, 2'b10);
    @(negedge clk); l2_addrOK = 1'b0; ch_req = 2'b00; #1;
    chk("wr_wait1_ch_dataOK", ch_dataOK, 2'b00);
    @(negedge clk); #1;
    chk("wr_wait2_ch_dataOK", ch_dataOK, 2'b00);
    @(negedge clk); l2_dataOK = 1'b1; #1;
    chk("wr_ch_dataOK", ch_dataOK, 2'b10);

    // Reset asserted mid-transaction in DATA
    @(negedge clk); l2_dataOK = 1'b0; ch_wr = 2'b00; ch_SUC = 2'b00;
    ch_req = 2'b01; ch_addr[31:0] = 32'h5000_0000;
    @(negedge clk); l2_addrOK = 1'b1; #1;
    chk("rs_ch_addrOK", ch_addrOK, 2'b01);
    @(negedge clk); l2_addrOK = 1'b0; ch_req = 2'b00; #1;
    @(negedge clk); l2_dataOK = 1'b1; l2_rdata = 128'hFFFF; rstn = 1'b0; #1;
    chk("rs_ch_dataOK", ch_dataOK, 2'b00);
    chk("rs_ch_rdata", ch_rdata, 128'h0);
    chk("rs_l2_req", l2_req, 1'b0);
    @(negedge clk); l2_dataOK = 1'b0; rstn = 1'b1; ch_req = 2'b11; #1;
    chk("rs_post_idle_l2_req", l2_req, 1'b0);
    @(negedge clk); l2_addrOK = 1'b1; #1;
    chk("rs_post_first_grant", ch_addrOK, 2'b01);
    @(negedge clk); l2_addrOK = 1'b0; ch_req = 2'b10; l2_dataOK = 1'b1; #1;
    chk("rs_post_first_done", ch_dataOK, 2'b01);
    @(negedge clk); l2_dataOK = 1'b0; #1;
    @(negedge clk); l2_addrOK = 1'b1; #1;
    chk("rs_post_ch1_grant", ch_addrOK, 2'b10);
    @(negedge clk); l2_addrOK = 1'b0; ch_req = 2'b00; l2_dataOK = 1'b1; #1;
    chk("rs_post_ch1_done", ch_dataOK, 2'b10);
    @(negedge clk); l2_dataOK = 1'b0;

    // Four channels, all requesting, eight transactions
    q_ch_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    for (int k = 0; k < 8; k++) begin
`ifdef L2ARB_RR_EN
      exp4 = 4'(1 << (k % 4));
`else
      exp4 = 4'b0001;
`endif
      @(negedge clk); q_l2_dataOK = 1'b0; q_ch_req = 4'hF; #1;
      chk("n4_bubble_l2_req", q_l2_req, 1'b0);
      @(negedge clk); q_l2_addrOK = 1'b1; #1;
      chk("n4_ch_addrOK", q_ch_addrOK, exp4);
      @(negedge clk); q_l2_addrOK = 1'b0; q_l2_dataOK = 1'b1; #1;
      chk("n4_ch_dataOK", q_ch_dataOK, exp4);
    end
    @(negedge clk); q_l2_dataOK = 1'b0; q_ch_req = 4'h0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
